rom_reader: RTL and testbench
=============================

// Module: rom_reader
// PURPOSE
//  Initiator-side controller for the synchronous-address instruction ROM macro (CS/OE/A/DO pins).
//  Turns a valid/ready word-read request into a correctly timed ROM access and returns data on a
//  valid/ready response channel. The ROM registers A on each CK edge and drives X until A has
//  been stable for two edges; this block guarantees DO is only sampled after that settle window.
//  Sits between the instruction-fetch unit and the ROM. Holds a one-entry last-word buffer so
//  repeated fetches of the same word skip the ROM.
// PARAMETERS
//  ADDR_SIZE      12  ROM word-address width
//  WORD_SIZE      32  ROM data width
//  SETTLE_CYCLES   1  extra CK cycles after address stability before capture (>=1; covers ROM read delay)
// PORTS
//  CK         in   1          clock, all logic on posedge
//  RST_N      in   1          asynchronous active-low reset
//  req_valid  in   1          read request valid
//  req_ready  out  1          request accepted when req_valid&&req_ready at posedge
//  req_addr   in   ADDR_SIZE  word address to read
//  rsp_valid  out  1          response data valid
//  rsp_ready  in   1          consumer accepts response at posedge
//  rsp_data   out  WORD_SIZE  read data
//  flush      in   1          invalidate last-word buffer (e.g. ROM image reload)
//  ROM_CS     out  1          ROM chip select
//  ROM_OE     out  1          ROM output enable
//  ROM_A      out  ADDR_SIZE  ROM address
//  ROM_DO     in   WORD_SIZE  ROM data out
// BEHAVIOUR
//  Reset (async, RST_N=0): state IDLE; req_ready=0 while held, 1 after release; rsp_valid=0;
//   rsp_data=0; ROM_CS=0; ROM_OE=0; ROM_A=0; buf_valid=0. In-flight access aborted, no response.
//  FSM: IDLE -> SETUP -> SETTLE -> RESP -> IDLE; hit path IDLE -> RESP.
//  IDLE: req_ready=1. On fire: if buf_valid && req_addr==buf_addr -> RESP, rsp_data=buf_data
//   (rsp_valid at next edge; 1-cycle latency). Else latch req_addr into ROM_A, ROM_CS=ROM_OE=1 -> SETUP.
//  SETUP: 2 cycles (ROM latches A, then prev_addr catches up); counter loaded on entry.
//  SETTLE: SETTLE_CYCLES cycles; at final edge capture ROM_DO into rsp_data and buf_data,
//   buf_addr=ROM_A, buf_valid=1 unless flush seen since request accepted; ROM_CS=ROM_OE=0 -> RESP.
//  Miss latency: request-fire edge to rsp_valid-high edge = 2+SETTLE_CYCLES edges (3 by default).
//  RESP: rsp_valid=1, rsp_data stable, req_ready=0 until rsp_ready; on rsp_valid&&rsp_ready -> IDLE
//   with rsp_valid=0. No request accepted in RESP (single outstanding read; fire-to-fire >= 2 cycles on hit).
//  ROM_A holds last issued address in all states (never toggles while idle) so the ROM stays settled.
//  ROM_CS/ROM_OE high only in SETUP and SETTLE.
//  flush: clears buf_valid at next edge in any state; if flush coincides with an IDLE hit, flush
//   wins and the access is treated as a miss. Flush during SETUP/SETTLE suppresses buffer fill but
//   the response is still delivered.
//  Simulation assertion: captured rsp_data on a miss must contain no X/Z bits.
// STRUCTURE
//  Package rom_pkg: state enum (IDLE, SETUP, SETTLE, RESP), default ADDR_SIZE/WORD_SIZE constants.
//  Sub-module rom_settle_cnt: loadable down-counter with done flag, used for SETUP and SETTLE waits.
//  Remainder (FSM, buffer, ROM pin registers) is flat in rom_reader.
// TESTING (bench instantiates ROM macro with read_delay < CK period, image mem[i]=i*0x01010101)
//  Miss read addr 0x005 -> rsp_data=0x05050505, rsp_valid rises 3 edges after fire; ROM_CS low after.
//  Repeat addr 0x005 -> hit: rsp_valid 1 edge after fire, ROM_CS/ROM_OE never assert.
//  flush then addr 0x005 -> full miss latency; SETTLE_CYCLES=3 build -> 5-edge latency, data correct.
//  rsp_ready held low 10 cycles -> rsp_valid/rsp_data stable, req_ready=0, new req_valid ignored.
//  RST_N pulled low mid-SETTLE -> all outputs reset immediately; next read of 0x0A0 returns 0xA0A0A0A0.
//  Back-to-back random addresses (1000 reads, random rsp_ready) -> every response matches model, no X.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared types and defaults for the instruction-ROM reader.
package rom_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int ADDR_SIZE_DEF = 12;
  localparam int WORD_SIZE_DEF = 32;
  // Edges needed for the ROM to register A and for its stability window to close.
  localparam int SETUP_CYCLES  = 2;

endpackage

// File: rtl/rom_settle_cnt.sv
// Loadable down-counter; done flags the last cycle of a timed wait.
module rom_settle_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on request, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rom_reader.sv
// Valid/ready front end for the synchronous-address instruction ROM with a
// one-entry last-word buffer. ROM_DO is only captured once A has been stable
// for two edges plus SETTLE_CYCLES of read delay.
module rom_reader
  import rom_pkg::*;
#(
  parameter int ADDR_SIZE     = ADDR_SIZE_DEF,
  parameter int WORD_SIZE     = WORD_SIZE_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 RST_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_SIZE-1:0] req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  input  logic                 flush,
  output logic                 ROM_CS,
  output logic                 ROM_OE,
  output logic [ADDR_SIZE-1:0] ROM_A,
  input  logic [WORD_SIZE-1:0] ROM_DO
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + SETUP_CYCLES) + 1;

  state_e               state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rom_en_q, rom_en_d;
  logic [ADDR_SIZE-1:0] rom_a_q, rom_a_d;
  logic                 buf_valid_q, buf_valid_d;
  logic                 flush_seen_q, flush_seen_d;
  logic [ADDR_SIZE-1:0] buf_addr_q, buf_addr_d;
  logic [WORD_SIZE-1:0] buf_data_q, buf_data_d;

  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_val;
  logic                 cnt_done;
  logic                 capture;

  rom_settle_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (CK),
    .rst_n    (RST_N),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  // Next-state logic: FSM transitions, pin values, buffer update and flush tracking.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rom_en_d     = rom_en_q;
    rom_a_d      = rom_a_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    buf_valid_d  = buf_valid_q & ~flush;
    flush_seen_d = flush_seen_q | flush;
    cnt_load     = 1'b0;
    cnt_val      = '0;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (buf_valid_q && (req_addr == buf_addr_q) && !flush) begin
            // Hit: data is ready now, rsp_valid follows on the next edge.
            state_d    = RESP;
            rsp_data_d = buf_data_q;
          end else begin
            state_d      = SETUP;
            rom_a_d      = req_addr;
            rom_en_d     = 1'b1;
            cnt_load     = 1'b1;
            cnt_val      = CNT_W'(SETUP_CYCLES);
            flush_seen_d = flush;
          end
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d  = SETTLE;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (cnt_done) begin
          capture     = 1'b1;
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ROM_DO;
          rom_en_d    = 1'b0;
          if (!(flush_seen_q || flush)) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = rom_a_q;
            buf_data_d  = ROM_DO;
          end
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  // Control state and registered outputs; reset aborts any in-flight access.
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rom_en_q     <= 1'b0;
      rom_a_q      <= '0;
      buf_valid_q  <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rom_en_q     <= rom_en_d;
      rom_a_q      <= rom_a_d;
      buf_valid_q  <= buf_valid_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  // Buffer payload; only meaningful while buf_valid_q is set.
  always_ff @(posedge CK) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  a_capture_known : assert property (@(posedge CK) disable iff (!RST_N)
                                     capture |-> !$isunknown(ROM_DO));

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ROM_CS    = rom_en_q;
  assign ROM_OE    = rom_en_q;
  assign ROM_A     = rom_a_q;

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: behavioural ROM macros plus a last-word buffer model.
module tb_rom_reader;

  logic        CK;
  logic        RST_N;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, flush;
  logic [11:0] req_addr, ROM_A;
  logic [31:0] rsp_data, ROM_DO;
  logic        ROM_CS, ROM_OE;

  logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, flush3;
  logic [11:0] req_addr3, ROM_A3;
  logic [31:0] rsp_data3, ROM_DO3;
  logic        ROM_CS3, ROM_OE3;

  int tests = 0;
  int fails = 0;
  int cs_edges = 0;

  rom_reader dut (
    .CK(CK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .flush(flush), .ROM_CS(ROM_CS), .ROM_OE(ROM_OE),
    .ROM_A(ROM_A), .ROM_DO(ROM_DO)
  );

  rom_reader #(.SETTLE_CYCLES(3)) dut3 (
    .CK(CK), .RST_N(RST_N), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_addr(req_addr3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .flush(flush3), .ROM_CS(ROM_CS3), .ROM_OE(ROM_OE3),
    .ROM_A(ROM_A3), .ROM_DO(ROM_DO3)
  );

  function automatic logic [31:0] img(input logic [11:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // ROM macros: A registered each edge, output X until stable for two edges, 2ns read delay.
  logic [11:0] a1, a2, b1, b2;
  always @(posedge CK) begin
    a2 <= a1; a1 <= ROM_A;
    b2 <= b1; b1 <= ROM_A3;
  end
  assign #2 ROM_DO  = (ROM_CS  && ROM_OE  && a1 == a2) ? img(a1) : 32'hxxxxxxxx;
  assign #2 ROM_DO3 = (ROM_CS3 && ROM_OE3 && b1 == b2) ? img(b1) : 32'hxxxxxxxx;

  always @(posedge CK) if (ROM_CS === 1'b1) cs_edges <= cs_edges + 1;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fire one request (fmode: 0 plain, 1 flush at fire, 2 flush one cycle later); return latency/data.
  task automatic issue(input logic [11:0] a, input int fmode, output int lat, output logic [31:0] d);
    int guard;
    guard = 0;
    @(negedge CK);
    while (req_ready !== 1'b1 && guard < 50) begin
      @(negedge CK);
      guard++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    flush     = (fmode == 1);
    @(posedge CK);
    #1;
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    flush     = (fmode == 2);
    lat = 0;
    while (lat < 20) begin
      @(posedge CK);
      lat++;
      #1;
      flush = 1'b0;
      if (rsp_valid === 1'b1) break;
    end
    d = rsp_data;
  endtask

  // Hold off the response for 'stall' cycles (optionally pushing a request), then accept it.
  task automatic accept(input int stall, input bit hold_req, input logic [31:0] exp_d);
    for (int i = 0; i < stall; i++) begin
      if (hold_req) begin
        req_valid = 1'b1;
        req_addr  = 12'h0FF;
      end
      @(negedge CK);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, exp_d);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge CK);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int          lat, cs0, guard, stall, fmode;
    logic [31:0] d;
    logic [11:0] a;
    logic        mv, hit;
    logic [11:0] ma;

    RST_N = 1'b0; req_valid = 0; rsp_ready = 0; flush = 0; req_addr = '0;
    req_valid3 = 0; rsp_ready3 = 0; flush3 = 0; req_addr3 = '0;
    mv = 1'b0; ma = '0;

    // Reset held
    repeat (3) @(posedge CK);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_cs", {31'd0, ROM_CS}, 32'd0);
    chk("rst_oe", {31'd0, ROM_OE}, 32'd0);
    chk("rst_rom_a", {20'd0, ROM_A}, 32'd0);
    @(negedge CK);
    RST_N = 1'b1;
    @(posedge CK);
    #1;
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // Miss then hit on 0x005
    issue(12'h005, 0, lat, d);
    chk("miss_lat", 32'(lat), 32'd3);
    chk("miss_data", d, 32'h05050505);
    chk("miss_cs_after", {31'd0, ROM_CS}, 32'd0);
    chk("miss_oe_after", {31'd0, ROM_OE}, 32'd0);
    accept(0, 1'b0, 32'h05050505);
    cs0 = cs_edges;
    issue(12'h005, 0, lat, d);
    chk("hit_lat", 32'(lat), 32'd1);
    chk("hit_data", d, 32'h05050505);
    accept(0, 1'b0, 32'h05050505);
    chk("hit_no_cs", 32'(cs_edges), 32'(cs0));

    // Stand-alone flush forces a miss
    @(negedge CK); flush = 1'b1;
    @(posedge CK); #1; flush = 1'b0;
    issue(12'h005, 0, lat, d);
    chk("flush_miss_lat", 32'(lat), 32'd3);
    chk("flush_miss_data", d, 32'h05050505);
    accept(0, 1'b0, 32'h05050505);

    // Consumer stall with a competing request
    issue(12'h00A, 0, lat, d);
    chk("stall_rd_data", d, 32'h0A0A0A0A);
    accept(10, 1'b1, 32'h0A0A0A0A);
    repeat (2) @(negedge CK);
    chk("stall_no_fire_a", {20'd0, ROM_A}, 32'h00A);
    chk("stall_no_fire_cs", {31'd0, ROM_CS}, 32'd0);

    // Flush during access: data delivered but buffer not filled
    issue(12'h033, 2, lat, d);
    chk("fl_mid_lat", 32'(lat), 32'd3);
    chk("fl_mid_data", d, 32'h33333333);
    accept(0, 1'b0, 32'h33333333);
    issue(12'h033, 0, lat, d);
    chk("fl_mid_nofill", 32'(lat), 32'd3);
    accept(0, 1'b0, 32'h33333333);
    issue(12'h033, 0, lat, d);
    chk("fl_refill_hit", 32'(lat), 32'd1);
    accept(0, 1'b0, 32'h33333333);
    // Flush coinciding with a hit wins
    issue(12'h033, 1, lat, d);
    chk("fl_hit_lat", 32'(lat), 32'd3);
    chk("fl_hit_data", d, 32'h33333333);
    accept(0, 1'b0, 32'h33333333);
    issue(12'h033, 0, lat, d);
    chk("fl_hit_nofill", 32'(lat), 32'd3);
    accept(0, 1'b0, 32'h33333333);

    // Reset in the middle of SETTLE
    @(negedge CK);
    req_valid = 1'b1; req_addr = 12'h0B0;
    @(posedge CK); #1; req_valid = 1'b0;
    @(posedge CK);
    @(posedge CK); #3;
    chk("pre_rst_cs", {31'd0, ROM_CS}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_cs", {31'd0, ROM_CS}, 32'd0);
    chk("mid_rst_oe", {31'd0, ROM_OE}, 32'd0);
    chk("mid_rst_a", {20'd0, ROM_A}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    @(negedge CK);
    RST_N = 1'b1;
    issue(12'h0A0, 0, lat, d);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", d, 32'hA0A0A0A0);
    accept(0, 1'b0, 32'hA0A0A0A0);
    mv = 1'b1; ma = 12'h0A0;

    // SETTLE_CYCLES=3 build
    guard = 0;
    @(negedge CK);
    while (req_ready3 !== 1'b1 && guard < 50) begin
      @(negedge CK);
      guard++;
    end
    chk("s3_ready", {31'd0, req_ready3}, 32'd1);
    req_valid3 = 1'b1; req_addr3 = 12'h005;
    @(posedge CK); #1; req_valid3 = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge CK);
      lat++;
      #1;
      if (rsp_valid3 === 1'b1) break;
    end
    chk("s3_lat", 32'(lat), 32'd5);
    chk("s3_data", rsp_data3, 32'h05050505);
    chk("s3_cs_after", {31'd0, ROM_CS3}, 32'd0);
    rsp_ready3 = 1'b1;
    @(posedge CK); #1; rsp_ready3 = 1'b0;
    chk("s3_drop", {31'd0, rsp_valid3}, 32'd0);

    // Random traffic against the buffer model
    for (int n = 0; n < 1000; n++) begin
      a     = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 7));
      fmode = $urandom_range(0, 15);
      fmode = (fmode == 0) ? 1 : ((fmode == 1) ? 2 : 0);
      stall = $urandom_range(0, 3);
      hit   = mv && (ma == a) && (fmode != 1);
      issue(a, fmode, lat, d);
      chk("rnd_lat", 32'(lat), hit ? 32'd1 : 32'd3);
      chk("rnd_data", d, img(a));
      accept(stall, 1'b0, img(a));
      if (fmode != 0) mv = 1'b0;
      else if (!hit) begin
        mv = 1'b1;
        ma = a;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
